// File: rtl/register_file.sv
// RV32I integer register file for the Decode stage.
// 2**ADDR_WIDTH general-purpose registers of DATA_WIDTH bits each, with x0 hardwired to zero.
// There are two combinational read ports (rs1/rs2) and one synchronous write port driven by writeback.
// With BYPASS=1, a read of the register being written in the same cycle returns write_data.
// This hides the WB->ID hazard.
// Reset is asynchronous and active-low. It clears every register and forces both reads to zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1_address,
  input  logic [ADDR_WIDTH-1:0] rs2_address,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] rs2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // A write only counts when out of reset, strobed, and not aimed at x0.
  // The same qualifier gates the bypass, so a discarded write is never forwarded either.
  logic w_write_hit;
  assign w_write_hit = reset & write_enable & (write_address != '0);

  // Storage: async clear, then one write per rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_hit) begin
      r_regs[write_address] <= write_data;
    end
  end

  // Read port 1: x0 and reset read zero; otherwise forward the in-flight write or the stored value.
  always_comb begin
    rs1 = '0;
    if (reset && (rs1_address != '0)) begin
      if (BYPASS && w_write_hit && (rs1_address == write_address)) begin
        rs1 = write_data;
      end else begin
        rs1 = r_regs[rs1_address];
      end
    end
  end

  // Read port 2: identical rule, independent address.
  always_comb begin
    rs2 = '0;
    if (reset && (rs2_address != '0)) begin
      if (BYPASS && w_write_hit && (rs2_address == write_address)) begin
        rs2 = write_data;
      end else begin
        rs2 = r_regs[rs2_address];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file.
// Two instances share every input: one with BYPASS=1, one with BYPASS=0.
// A behavioural model (a plain array plus the read rules) predicts both.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW-1:0] rs1_address, rs2_address, write_address;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [DW-1:0] rs1_b, rs2_b, rs1_n, rs2_n;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) u_byp (
    .clock(clock), .reset(reset),
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
    .rs1(rs1_b), .rs2(rs2_b)
  );

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) u_nobyp (
    .clock(clock), .reset(reset),
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
    .rs1(rs1_n), .rs2(rs2_n)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endfunction

  // Value the spec says a read port shows right now.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input bit byp);
    if (reset !== 1'b1 || a == 0) return '0;
    if (byp && write_enable === 1'b1 && write_address != 0 && write_address == a) return write_data;
    return model[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    write_enable  = we;
    write_address = wa;
    write_data    = wd;
    rs1_address   = a1;
    rs2_address   = a2;
  endtask

  // Advance one cycle: the model commits at the rising edge, and control returns at the falling edge.
  task automatic step();
    @(posedge clock);
    if (reset === 1'b1 && write_enable === 1'b1 && write_address != 0)
      model[write_address] = write_data;
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    drive(1'b1, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd6);
    #2;
    n_vec++;
    if (rs1_b !== 32'd0 || rs2_b !== 32'd0) begin
      n_err++;
      $display("FAIL reset_held_bypass rs1=%h rs2=%h expected 0 0", rs1_b, rs2_b);
    end
    #8;                                   // t=10: release reset between edges
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    reset = 1'b1;
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs2_b !== 32'd0 || rs1_n !== 32'd0 || rs2_n !== 32'd0) begin
      n_err++;
      $display("FAIL reset_x0 rs1=%h rs2=%h expected 0 0", rs1_b, rs2_b);
    end
    rs1_address = 5'd4;
    rs2_address = 5'd6;
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs2_b !== 32'd0 || rs1_n !== 32'd0 || rs2_n !== 32'd0) begin
      n_err++;
      $display("FAIL reset_x4_x6 rs1=%h rs2=%h expected 0 0", rs1_b, rs2_b);
    end
    @(negedge clock);
  endtask

  task automatic test_write();
    logic [AW-1:0] a1 [3];
    logic [AW-1:0] a2 [3];
    logic [DW-1:0] e1 [3];
    logic [DW-1:0] e2 [3];
    a1 = '{5'd0, 5'd1, 5'd2};
    a2 = '{5'd1, 5'd2, 5'd3};
    e1 = '{32'd0, 32'd50, 32'd30};
    e2 = '{32'd50, 32'd30, 32'd40};
    drive(1'b1, 5'd1, 32'd20, 5'd0, 5'd0); step();
    drive(1'b1, 5'd2, 32'd30, 5'd0, 5'd0); step();
    drive(1'b1, 5'd3, 32'd40, 5'd0, 5'd0); step();
    drive(1'b1, 5'd1, 32'd50, 5'd0, 5'd0); step();
    write_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rs1_address = a1[k];
      rs2_address = a2[k];
      #1;
      n_vec++;
      if (rs1_b !== e1[k] || rs2_b !== e2[k] || rs1_n !== e1[k] || rs2_n !== e2[k]) begin
        n_err++;
        $display("FAIL write_read_%0d rs1=%0d/%0d rs2=%0d/%0d expected %0d %0d",
                 k, rs1_b, rs1_n, rs2_b, rs2_n, e1[k], e2[k]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs2_b !== 32'd0 || rs1_n !== 32'd0 || rs2_n !== 32'd0) begin
      n_err++;
      $display("FAIL x0_bypass rs1=%h rs2=%h expected 0 0", rs1_b, rs2_b);
    end
    step();
    write_enable = 1'b0;
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs2_b !== 32'd0 || rs1_n !== 32'd0 || rs2_n !== 32'd0) begin
      n_err++;
      $display("FAIL x0_stored rs1=%h rs2=%h expected 0 0", rs1_b, rs2_b);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
    #1;
    n_vec++;
    if (rs1_b !== 32'h1234_5678 || rs2_b !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL bypass_on rs1=%h rs2=%h expected 12345678 12345678", rs1_b, rs2_b);
    end
    n_vec++;
    if (rs1_n !== 32'd0 || rs2_n !== 32'd0) begin
      n_err++;
      $display("FAIL bypass_off_before rs1=%h rs2=%h expected 0 0", rs1_n, rs2_n);
    end
    step();
    write_enable = 1'b0;
    #1;
    n_vec++;
    if (rs1_n !== 32'h1234_5678 || rs2_n !== 32'h1234_5678 || rs1_b !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL bypass_after rs1=%h rs2=%h expected 12345678 12345678", rs1_n, rs2_n);
    end
  endtask

  task automatic test_no_write();
    drive(1'b0, 5'd7, 32'd99, 5'd7, 5'd7);
    step();
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs1_n !== 32'd0 || rs2_b !== 32'd0) begin
      n_err++;
      $display("FAIL we_low_x7 rs1=%0d expected 0", rs1_b);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd10, 32'hA5A5_A5A5, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
    #1;
    n_vec++;
    if (rs1_b !== 32'hA5A5_A5A5 || rs1_n !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL x10_written rs1=%h expected a5a5a5a5", rs1_b);
    end
    #1;                                   // between edges
    reset = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs1_n !== 32'd0) begin
      n_err++;
      $display("FAIL async_clear rs1=%h expected 0", rs1_b);
    end
    // A write attempted across an edge while reset is low must be discarded.
    drive(1'b1, 5'd11, 32'hCAFE_F00D, 5'd10, 5'd11);
    #1;
    n_vec++;
    if (rs2_b !== 32'd0) begin
      n_err++;
      $display("FAIL reset_bypass_blocked rs2=%h expected 0", rs2_b);
    end
    step();
    write_enable = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++;
    if (rs1_b !== 32'd0 || rs1_n !== 32'd0 || rs2_b !== 32'd0 || rs2_n !== 32'd0) begin
      n_err++;
      $display("FAIL after_release rs1=%h rs2=%h expected 0 0", rs1_b, rs2_b);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [AW-1:0] wa;
    logic [DW-1:0] got;
    for (int it = 0; it < 400; it++) begin
      wa = AW'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31)));
      #1;
      exp_q.push_back(ref_read(rs1_address, 1'b1));
      exp_q.push_back(ref_read(rs2_address, 1'b1));
      exp_q.push_back(ref_read(rs1_address, 1'b0));
      exp_q.push_back(ref_read(rs2_address, 1'b0));
      for (int p = 0; p < 4; p++) begin
        case (p)
          0: got = rs1_b;
          1: got = rs2_b;
          2: got = rs1_n;
          default: got = rs2_n;
        endcase
        n_vec++;
        if (got !== exp_q[0]) begin
          n_err++;
          $display("FAIL random_it%0d_port%0d got=%h expected %h (we=%b wa=%0d a1=%0d a2=%0d)",
                   it, p, got, exp_q[0], write_enable, write_address, rs1_address, rs2_address);
        end
        void'(exp_q.pop_front());
      end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_x0();
    test_bypass();
    test_no_write();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
